// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing and four-mode test-pattern generator.
// Ports: CLOCK_50/RESET_N (async, active low) in; MODE selects the pattern and is
// sampled at frame wrap only; VGA_R/G/B colour data, VGA_CLK pixel clock,
// VGA_BLANK (1 = visible), VGA_HS/VGA_VS syncs, and FRAME_START, a one-cycle
// pulse when the counters wrap to (0,0).
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CLK_DIV = 2,
  parameter int COLOR_W = 10,
  parameter int CHK_BIT = 5
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic [1:0]         MODE,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_CLK,
  output logic               VGA_BLANK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               FRAME_START
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are wide enough for the totals and for the fixed bit taps (bit 6, [7:0], CHK_BIT).
  localparam int CW_T = $clog2(H_TOTAL) > $clog2(V_TOTAL) ? $clog2(H_TOTAL) : $clog2(V_TOTAL);
  localparam int CW_C = CHK_BIT + 1 > 8 ? CHK_BIT + 1 : 8;
  localparam int CW = CW_T > CW_C ? CW_T : CW_C;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW = BAR_W > 1 ? $clog2(BAR_W) : 1;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic [COLOR_W-1:0] FULL = '1;

  logic [DW-1:0] div_cnt, div_nxt;
  logic pix_ce, h_wrap, v_wrap, vis, hs_on, vs_on, bar_on;
  logic [CW-1:0] h_cnt, v_cnt;
  logic [BW-1:0] bar_pos;
  logic [3:0] bar_idx;
  logic [1:0] mode_q;
  logic [7:0] frame_cnt, scroll;
  logic [COLOR_W-1:0] r_n, g_n, b_n;

  assign pix_ce = div_cnt == DIV_LAST;
  assign div_nxt = pix_ce ? '0 : div_cnt + DW'(1);
  assign h_wrap = h_cnt == H_LAST;
  assign v_wrap = v_cnt == V_LAST;
  assign vis = h_cnt < H_VIS && v_cnt < V_VIS;
  assign hs_on = h_cnt >= HS_BEG && h_cnt < HS_END;
  assign vs_on = v_cnt >= VS_BEG && v_cnt < VS_END;
  assign scroll = h_cnt[7:0] + frame_cnt;
  // bar_idx saturates at 8, which covers the black remainder beyond 8 bars.
  assign bar_on = !bar_idx[3];

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    case (mode_q)
      2'd0: begin
        r_n = v_cnt[6] ? FULL : '0;
        g_n = h_cnt[6] ? FULL : '0;
        b_n = (h_cnt[6] && v_cnt[6]) ? FULL :
              (!h_cnt[6] && !v_cnt[6]) ? COLOR_W'(v_cnt[5:0]) << (COLOR_W - 6) : '0;
      end
      // Bar order white, yellow, cyan, green, magenta, red, blue, black falls out of the index bits.
      2'd1: begin
        r_n = {COLOR_W{bar_on & ~bar_idx[1]}};
        g_n = {COLOR_W{bar_on & ~bar_idx[2]}};
        b_n = {COLOR_W{bar_on & ~bar_idx[0]}};
      end
      2'd2: begin
        r_n = {COLOR_W{h_cnt[CHK_BIT] ^ v_cnt[CHK_BIT]}};
        g_n = {COLOR_W{h_cnt[CHK_BIT] ^ v_cnt[CHK_BIT]}};
        b_n = {COLOR_W{h_cnt[CHK_BIT] ^ v_cnt[CHK_BIT]}};
      end
      default: begin
        r_n = COLOR_W'(scroll) << (COLOR_W - 8);
        g_n = COLOR_W'(v_cnt[7:0]) << (COLOR_W - 8);
      end
    endcase
  end

  // VGA_CLK follows the upper half of the divider so pix_ce lands while it is high.
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      div_cnt <= '0;
      VGA_CLK <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      VGA_CLK <= div_nxt >= DIV_HALF;
      FRAME_START <= pix_ce && h_wrap && v_wrap;
    end

  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
      bar_pos <= '0;
      bar_idx <= '0;
      mode_q <= 2'd0;
      frame_cnt <= 8'd0;
    end else if (pix_ce) begin
      h_cnt <= h_wrap ? '0 : h_cnt + CW'(1);
      bar_pos <= (h_wrap || bar_pos == BAR_LAST) ? '0 : bar_pos + BW'(1);
      bar_idx <= h_wrap ? 4'd0 : (bar_pos == BAR_LAST && bar_on) ? bar_idx + 4'd1 : bar_idx;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + CW'(1);
      if (h_wrap && v_wrap) begin
        mode_q <= MODE;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end

  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
      VGA_BLANK <= 1'b0;
      VGA_HS <= ~HS_POL;
      VGA_VS <= ~VS_POL;
    end else if (pix_ce) begin
      VGA_R <= vis ? r_n : '0;
      VGA_G <= vis ? g_n : '0;
      VGA_B <= vis ? b_n : '0;
      VGA_BLANK <= vis;
      VGA_HS <= hs_on ? HS_POL : ~HS_POL;
      VGA_VS <= vs_on ? VS_POL : ~VS_POL;
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench for vga_pattern_gen with a reduced raster.
module tb_vga_pattern_gen;
  localparam int HA = 74, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 66, VFP = 1, VSY = 2, VBP = 1;
  localparam int D = 2, CHK = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FC = D * HT * VT;
  localparam int FULL = 1023;

  typedef struct packed {
    logic [9:0] r, g, b;
    logic blank, hs, vs;
  } pix_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] mode = 2'd3;
  logic [9:0] r, g, b;
  logic vclk, blank, hs, vs, fs;
  int checks = 0, failures = 0, cyc = 0, pops = 0;
  bit mon_en = 0, prev_vclk = 0;
  pix_t sb[$];
  int fm[5];

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(D), .COLOR_W(10), .CHK_BIT(CHK)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .MODE(mode),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_CLK(vclk), .VGA_BLANK(blank),
    .VGA_HS(hs), .VGA_VS(vs), .FRAME_START(fs)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endfunction

  function automatic pix_t model(input int h, input int v, input int m, input int fc);
    logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    logic [2:0] c;
    pix_t p;
    int bi, q;
    p = '0;
    p.blank = h < HA && v < VA;
    p.hs = (h >= HA + HFP && h < HA + HFP + HSY) ? 1'b0 : 1'b1;
    p.vs = (v >= VA + VFP && v < VA + VFP + VSY) ? 1'b1 : 1'b0;
    if (p.blank) begin
      case (m)
        0: begin
          q = 2 * ((h / 64) % 2) + (v / 64) % 2;
          if (q == 0) p.b = 10'((v % 64) * 16);
          else if (q == 1) p.r = 10'(FULL);
          else if (q == 2) p.g = 10'(FULL);
          else begin p.r = 10'(FULL); p.g = 10'(FULL); p.b = 10'(FULL); end
        end
        1: begin
          bi = h / (HA / 8);
          c = bi < 8 ? bars[bi] : 3'b000;
          p.r = c[2] ? 10'(FULL) : 10'd0;
          p.g = c[1] ? 10'(FULL) : 10'd0;
          p.b = c[0] ? 10'(FULL) : 10'd0;
        end
        2: if (((h >> CHK) + (v >> CHK)) % 2 == 1) begin
          p.r = 10'(FULL); p.g = 10'(FULL); p.b = 10'(FULL);
        end
        default: begin
          p.r = 10'(((h + fc) % 256) * 4);
          p.g = 10'((v % 256) * 4);
        end
      endcase
    end
    return p;
  endfunction

  task automatic push_frame(input int m, input int fc);
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) sb.push_back(model(h, v, m, fc));
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Changes MODE twice inside frame f; only the value held at the wrap may take effect.
  task automatic frame_mid(input int f, input int nxt);
    wait_cyc(FC * f + $urandom_range(D, FC / 3));
    mode = 2'($urandom);
    wait_cyc(FC * f + $urandom_range(FC / 2, FC - 4));
    mode = 2'(nxt);
    push_frame(nxt, f + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_r"}, 64'(r), 0);
    check({tag, "_g"}, 64'(g), 0);
    check({tag, "_b"}, 64'(b), 0);
    check({tag, "_blank"}, 64'(blank), 0);
    check({tag, "_vclk"}, 64'(vclk), 0);
    check({tag, "_fs"}, 64'(fs), 0);
    check({tag, "_hs"}, 64'(hs), 1);
    check({tag, "_vs"}, 64'(vs), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("vga_clk", 64'(vclk), 64'((cyc % D) >= D / 2));
      check("frame_start", 64'(fs), 64'(cyc > 0 && cyc % FC == 0));
      if (prev_vclk && !vclk) begin
        if (sb.size() == 0) check("sb_underflow", 64'(pops), 64'(-1));
        else check($sformatf("pix%0d", pops), 64'({r, g, b, blank, hs, vs}), 64'(sb.pop_front()));
        pops++;
      end
    end
    prev_vclk = mon_en && vclk;
  end

  initial begin
    #1_500_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int t, j;
    fm[0] = 0;
    for (int i = 1; i < 5; i++) fm[i] = i - 1;
    for (int i = 4; i > 1; i--) begin
      j = $urandom_range(1, i);
      t = fm[i]; fm[i] = fm[j]; fm[j] = t;
    end
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("por");
    #1 rst_n = 1'b1;
    push_frame(0, 0);
    mon_en = 1;
    for (int f = 0; f < 4; f++) frame_mid(f, fm[f + 1]);
    wait_cyc(4 * FC + D * (HT * 30 + 10));
    #2 mon_en = 0;
    rst_n = 1'b0;
    sb.delete();
    #1 check_reset_outputs("async");
    repeat (3) @(negedge clk);
    check_reset_outputs("held");
    #2 rst_n = 1'b1;
    push_frame(0, 0);
    mon_en = 1;
    frame_mid(0, 3);
    wait_cyc(FC + D * HT * 2);
    mon_en = 0;
    check("pixels_seen", 64'(pops > 5 * HT * VT), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA timing and test-pattern generator; successor to the fixed 640x480 quadrant-stripe generator. Derives the pixel clock enable from CLOCK_50, generates programmable horizontal and vertical timing, and drives the DAC colour buses with one of four run-time-selectable patterns. It sits directly at the VGA DAC pins and serves as a bring-up and reference source for later framebuffer blocks.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal front porch, sync, back porch, in pixels
- V_ACTIVE, 480: visible lines
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical front porch, sync, back porch, in lines
- HS_POL, 0 / VS_POL, 0: sync active level (0 = active low)
- CLK_DIV, 2: CLOCK_50 cycles per pixel; even, ≥2
- COLOR_W, 10: colour channel width; ≥8
- CHK_BIT, 5: checker square size = 2^CHK_BIT pixels
- CLOCK_50  in  1  system clock
- RESET_N  in  1  asynchronous reset, active low
- MODE  in  2  pattern select; sampled at frame start only
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  colour data
- VGA_CLK  out  1  pixel clock to DAC
- VGA_BLANK  out  1  active-low blank: 1 during visible pixels
- VGA_HS, VGA_VS  out  1  syncs, polarity per HS_POL/VS_POL
- FRAME_START  out  1  one-CLOCK_50 pulse when the counters wrap to (0,0)

## Operation
- Divider div_cnt counts 0..CLK_DIV-1. pix_ce = (div_cnt == CLK_DIV-1). VGA_CLK registered, high while div_cnt ≥ CLK_DIV/2, so the pix_ce edge is mid-high of VGA_CLK.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. On pix_ce: h_cnt increments and wraps H_TOTAL-1→0; v_cnt increments only on that wrap and wraps V_TOTAL-1→0.
- Sync active when h_cnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vertical likewise with v_cnt.
- Visible = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. Outside visible area RGB = 0 and VGA_BLANK = 0.
- mode_q and frame_cnt (8 bits, wrapping) update on the pix_ce where both counters wrap; at the same time FRAME_START pulses. MODE changes mid-frame have no effect until then.
- "Full" = all ones; "MSB-aligned x" = x in the top bits, zeros below.
- Mode 0 QUAD, selected by {h_cnt[6], v_cnt[6]}: 0 → R=G=0, B = MSB-aligned v_cnt[5:0]; 1 → R full, G=B=0; 2 → G full, R=B=0; 3 → white.
- Mode 1 BARS: bar width W = H_ACTIVE/8 (integer), tracked by a bar counter, no divider. Bar index b = 0..7 is white, yellow, cyan, green, magenta, red, blue, black.
  - R full iff b ∈ {0,1,4,5}; G full iff b ∈ {0,1,2,3}; B full iff b ∈ {0,2,4,6}.
  - Remainder pixels beyond 8W are black.
- Mode 2 CHECKER: white if h_cnt[CHK_BIT] ^ v_cnt[CHK_BIT], else black.
- Mode 3 SCROLL: R = MSB-aligned (h_cnt + frame_cnt) mod 256; G = MSB-aligned v_cnt[7:0]; B = 0.
- Reset, asynchronous: all counters, mode_q and frame_cnt go to 0. RGB = 0, VGA_BLANK = 0, VGA_CLK = 0, FRAME_START = 0, syncs at their inactive level. After release, timing restarts at (0,0) with mode_q = 0 until the first frame wrap. Reset mid-line truncates the line; no partial-state recovery is required.

## Timing
- RGB, VGA_BLANK, VGA_HS and VGA_VS are all registered on the same pix_ce edge from the same (h_cnt, v_cnt, mode_q). They are therefore mutually aligned, with one pixel period of latency from counter to pin.
- Outputs change only on pix_ce cycles. FRAME_START is high for exactly one CLOCK_50 cycle per frame.
- The first visible pixel of a frame appears one pixel period after FRAME_START.
- Frame period = H_TOTAL × V_TOTAL × CLK_DIV CLOCK_50 cycles. With defaults this is 800 × 525 × 2 = 840000.

## Test plan
- Defaults, reset then run 2 frames -> FRAME_START period 840000 cycles; VGA_CLK period 2 cycles; HS low for 192 cycles per line, starting 1 pixel after h_cnt=656; VS low for exactly 2 lines (1600 pixels), lines 490-491.
- MODE=1 held -> on line 0, pixel 0 = white (all 1023), pixel 80 = yellow (R=G=1023, B=0), pixel 639 = black; pixels 640-799 blank with RGB=0.
- MODE=0 -> pixel (64,0) is full green; (0,64) is full red; (64,64) is white; (0,63) gives B = 63<<4 = 1008.
- MODE switched 0→2 at mid-frame (line 200) -> remainder of the frame stays QUAD; next frame is CHECKER, with (32,0) = white and (32,32) = black.
- MODE=3 for 3 frames -> pixel (0,0) R equals frame_cnt<<2: values 4, 8, 12 on frames 1, 2, 3 after the first wrap; frame_cnt wraps 255→0.
- RESET_N pulsed low mid-line 100 for 3 cycles -> outputs reach reset values immediately without waiting for a clock edge; after release the next FRAME_START arrives 840000 cycles later.
